// File: rtl/mux_4x1_pkg.sv
// Shared constants for the 4:1 lane multiplexer.
package mux_4x1_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  localparam logic [SEL_W-1:0] SEL_LANE0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_LANE1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_LANE2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_LANE3 = 2'd3;

endpackage

// File: rtl/mux_4x1_lane_sel.sv
// Combinational WIDTH-bit 4:1 lane selector; lane 0 sits in the LSBs of i.
module mux_4x1_lane_sel
  import mux_4x1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [NUM_LANES*WIDTH-1:0] i,
  input  logic [SEL_W-1:0]           sel,
  output logic [WIDTH-1:0]           y
);

  logic [WIDTH-1:0] lanes [NUM_LANES];

  // Split the packed input into individual lanes.
  always_comb begin
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      lanes[k] = i[k*WIDTH +: WIDTH];
    end
  end

  // Full-case select with lane 0 as the fallback; an unknown select
  // propagates as all-X in simulation rather than silently picking lane 0.
  always_comb begin
    y = lanes[0];
    case (sel)
      SEL_LANE0: y = lanes[0];
      SEL_LANE1: y = lanes[1];
      SEL_LANE2: y = lanes[2];
      SEL_LANE3: y = lanes[3];
      default:   y = lanes[0];
    endcase
    if ($isunknown(sel)) begin
      y = 'x;
    end
  end

endmodule

// File: rtl/mux_4x1.sv
// 4:1 multiplexer with a combinational output plus a registered output
// and valid flag that capture the selected lane whenever in_valid is high.
module mux_4x1
  import mux_4x1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_LANES*WIDTH-1:0] i,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           y_comb,
  output logic [WIDTH-1:0]           y,
  output logic                       y_valid
);

  mux_4x1_lane_sel #(
    .WIDTH (WIDTH)
  ) u_lane_sel (
    .i   (i),
    .sel (sel),
    .y   (y_comb)
  );

  // Capture the selected lane on accepted samples; valid is a one-cycle echo of in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= in_valid;
      if (in_valid) begin
        y <= y_comb;
      end
    end
  end

endmodule

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1: a WIDTH=1 instance for the exhaustive
// combinational sweep and a WIDTH=8 instance for the registered path.
module tb_mux_4x1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic [3:0]  i1;
  logic [1:0]  sel1;
  logic        iv1;
  logic [0:0]  y_comb1, y1;
  logic        y_valid1;

  logic [31:0] i8;
  logic [1:0]  sel8;
  logic        iv8;
  logic [7:0]  y_comb8, y8;
  logic        y_valid8;

  int passed = 0;
  int total  = 0;

  // Reference model state for the registered path.
  logic [7:0] m_y;
  logic       m_v;

  always #5 clk = ~clk;

  mux_4x1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i(i1), .sel(sel1), .in_valid(iv1),
    .y_comb(y_comb1), .y(y1), .y_valid(y_valid1)
  );

  mux_4x1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i(i8), .sel(sel8), .in_valid(iv8),
    .y_comb(y_comb8), .y(y8), .y_valid(y_valid8)
  );

  function automatic logic [7:0] lane8(input logic [31:0] v, input logic [1:0] s);
    logic [31:0] t;
    t = v >> (8 * int'(s));
    return t[7:0];
  endfunction

  function automatic logic [7:0] bit1(input logic [3:0] v, input logic [1:0] s);
    logic [3:0] t;
    t = v >> s;
    return {7'd0, t[0]};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one sample, check the combinational output, then check the
  // registered outputs one cycle after the sampling edge.
  task automatic step(input logic [31:0] ni, input logic [1:0] ns, input logic niv,
                      input string tag);
    i8 = ni; sel8 = ns; iv8 = niv;
    #1;
    check({tag, "/comb"}, y_comb8, lane8(ni, ns));
    if (niv) m_y = lane8(ni, ns);
    m_v = niv;
    @(posedge clk); #1;
    check({tag, "/y"}, y8, m_y);
    check({tag, "/valid"}, {7'd0, y_valid8}, {7'd0, m_v});
  endtask

  initial begin
    i1 = '0; sel1 = '0; iv1 = 1'b0;
    i8 = '0; sel8 = '0; iv8 = 1'b0;
    m_y = '0; m_v = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check("reset_y8", y8, 8'h00);
    check("reset_v8", {7'd0, y_valid8}, 8'h00);
    check("reset_y1", {7'd0, y1}, 8'h00);

    // Exhaustive WIDTH=1 sweep, run while reset is held.
    for (int v = 0; v < 16; v++) begin
      for (int s = 0; s < 4; s++) begin
        i1 = 4'(v); sel1 = 2'(s);
        #1;
        check($sformatf("sweep_i%0h_s%0d", v, s), {7'd0, y_comb1}, bit1(4'(v), 2'(s)));
        #4;
      end
    end

    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_y", y8, 8'h00);
    check("post_reset_v", {7'd0, y_valid8}, 8'h00);

    // Registered capture and hold-after-capture.
    step(32'hDDCCBBAA, 2'd2, 1'b1, "capture");
    step(32'hDDCCBBAA, 2'd2, 1'b0, "capture_hold");

    // Hold: inputs wander with in_valid low.
    for (int n = 0; n < 4; n++) step($urandom, 2'($urandom_range(0, 3)), 1'b0, "hold");

    // Back-to-back streaming through all four lanes.
    for (int s = 0; s < 4; s++) step(32'h44332211, 2'(s), 1'b1, $sformatf("stream%0d", s));

    // Asynchronous reset mid-stream with a pending sample.
    step(32'hDDCCBBAA, 2'd2, 1'b1, "pre_reset");
    i8 = 32'h12345678; sel8 = 2'd1; iv8 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_y", y8, 8'h00);
    check("async_rst_v", {7'd0, y_valid8}, 8'h00);
    check("async_rst_comb", y_comb8, 8'h56);
    m_y = '0; m_v = 1'b0;
    @(posedge clk); #1;
    check("in_reset_y", y8, 8'h00);
    iv8 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_rst_v", {7'd0, y_valid8}, 8'h00);
    step(32'hCAFEF00D, 2'd3, 1'b1, "first_after_rst");

    // Edge-coincident select change: the pre-edge lane is captured.
    i8 = 32'hA1B2C3D4; sel8 = 2'd1; iv8 = 1'b1;
    @(posedge clk);
    sel8 <= 2'd3;
    #1;
    check("edge_sel_y", y8, 8'hC3);
    check("edge_sel_v", {7'd0, y_valid8}, 8'h01);
    m_y = 8'hC3; m_v = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++)
      step($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand");

    check("w1_y_idle", {7'd0, y1}, 8'h00);
    check("w1_v_idle", {7'd0, y_valid1}, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
